// File: rtl/debug_rom_bus_adapter_if.sv
// ============================================================================
// debug_rom_bus_adapter_if : core debug-memory port plus ROM read port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface debug_rom_bus_adapter_if;
  logic        req_i;
  logic        gnt_o;
  logic [63:0] addr_i;
  logic        we_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rom_req_o;
  logic [63:0] rom_addr_o;
  logic [63:0] rom_rdata_i;

  modport master (
    output req_i, addr_i, we_i, rready_i, rom_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, rom_req_o, rom_addr_o
  );

  modport slave (
    input  req_i, addr_i, we_i, rready_i, rom_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, rom_req_o, rom_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/debug_rom_bus_adapter.sv
// ============================================================================
// debug_rom_bus_adapter : debug ROM front end, in-order credit-limited reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module debug_rom_bus_adapter #(
  parameter int unsigned RomSize  = 19,
  parameter logic [63:0] BaseAddr = 64'h800,
  parameter int unsigned RspDepth = 2
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  debug_rom_bus_adapter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RspDepth + 1);
  localparam int unsigned PTR_W = $clog2(RspDepth);

  logic [63:0]      offset;
  logic             ok;
  logic             acc;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] buf_count;
  logic             buf_empty;
  logic             push;
  logic             pop;

  logic             s1_valid;
  logic             s1_hi;
  logic             s1_err;
  logic [31:0]      s1_data;

  logic [32:0]      mem [RspDepth];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RspDepth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Range check only trusts the offset once addr_i >= BaseAddr, so wrapped
  // addresses can never alias into the ROM.
  assign offset  = bus.addr_i - BaseAddr;
  assign ok      = !bus.we_i && (bus.addr_i[1:0] == 2'b00) &&
                   (bus.addr_i >= BaseAddr) && ((offset >> 3) < 64'(RomSize));
  assign out_cnt = CNT_W'(s1_valid) + buf_count;
  assign bus.gnt_o = (out_cnt < CNT_W'(RspDepth));
  assign acc       = bus.req_i && bus.gnt_o;

  assign bus.rom_req_o  = acc && ok;
  assign bus.rom_addr_o = offset;

  assign s1_data = s1_err ? 32'h0 :
                   s1_hi  ? bus.rom_rdata_i[63:32] : bus.rom_rdata_i[31:0];

  assign buf_empty = (buf_count == '0);
  assign push      = s1_valid && (!buf_empty || !bus.rready_i);
  assign pop       = !buf_empty && bus.rready_i;

  always_comb begin
    bus.rvalid_o = 1'b0;
    bus.rdata_o  = 32'h0;
    bus.err_o    = 1'b0;
    if (!buf_empty) begin
      bus.rvalid_o = 1'b1;
      {bus.rdata_o, bus.err_o} = mem[rd_ptr];
    end else if (s1_valid) begin
      bus.rvalid_o = 1'b1;
      bus.rdata_o  = s1_data;
      bus.err_o    = s1_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_hi    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= acc;
      s1_hi    <= acc && bus.addr_i[2];
      s1_err   <= acc && !ok;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_count <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      buf_count <= buf_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // ROM data is only valid for one cycle, so it is captured into the buffer
  // whenever the fall-through path cannot deliver it immediately.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {s1_data, s1_err};
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (buf_count == CNT_W'(RspDepth)) && !pop));

endmodule

`default_nettype wire

// File: tb/tb_debug_rom_bus_adapter.sv
// ============================================================================
// tb_debug_rom_bus_adapter : scoreboard bench with ROM model and random reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_debug_rom_bus_adapter;
  localparam int          DEPTH = 2;
  localparam int          ROMW  = 19;
  localparam logic [63:0] BASE  = 64'h800;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_rom_bus_adapter_if bus();

  debug_rom_bus_adapter #(
    .RomSize (ROMW),
    .BaseAddr(BASE),
    .RspDepth(DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  logic [63:0] rom [ROMW];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.rom_req_o && (bus.rom_addr_o >> 3) < 64'(ROMW))
      bus.rom_rdata_i <= rom[int'(bus.rom_addr_o >> 3)];
    else
      bus.rom_rdata_i <= {$urandom(), $urandom()};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [63:0] a, input bit we,
                                output logic [31:0] d, output logic e, output bit ok);
    logic [63:0] w;
    ok = !we && a[1:0] == 2'b00 && a >= BASE && (a - BASE) / 8 < 64'(ROMW);
    e  = !ok;
    d  = 32'h0;
    if (ok) begin
      w = rom[int'((a - BASE) / 8)];
      d = a[2] ? w[63:32] : w[31:0];
    end
  endfunction

  task automatic drive(input bit req, input logic [63:0] addr, input bit we, input bit rdy);
    bit          eg;
    bit          ok;
    logic [31:0] d;
    logic        e;
    @(negedge clk);
    bus.req_i    = req;
    bus.addr_i   = addr;
    bus.we_i     = we;
    bus.rready_i = rdy;
    #3;
    if (rst_n) begin
      eg = q.size() < DEPTH;
      chk("gnt", 64'(bus.gnt_o), 64'(eg));
      if (req && eg) begin
        model(addr, we, d, e, ok);
        chk("rom_req", 64'(bus.rom_req_o), 64'(ok));
        if (ok) chk("rom_addr", bus.rom_addr_o, addr - BASE);
        q.push_back('{data: d, err: e, cyc: cyc});
      end else begin
        chk("rom_req_idle", 64'(bus.rom_req_o), 64'h0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_i = 1'b0;
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("rst_rdata", 64'(bus.rdata_o), 64'h0);
    chk("rst_err", 64'(bus.err_o), 64'h0);
    chk("rst_rom_req", 64'(bus.rom_req_o), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: the oldest outstanding response is due from the cycle after acceptance
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("rvalid_due", 64'(bus.rvalid_o), 64'h1);
          if (bus.rvalid_o) begin
            chk("rdata", 64'(bus.rdata_o), 64'(q[0].data));
            chk("err", 64'(bus.err_o), 64'(q[0].err));
            if (bus.rready_i) void'(q.pop_front());
          end
        end else if (bus.rvalid_o) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual=1 required=0 (t=%0t)", $time);
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    int          r;
    rom[0] = 64'h07c0006f_00c0006f;
    for (int i = 1; i < ROMW; i++) rom[i] = {$urandom(), $urandom()};
    bus.req_i = 1'b0; bus.addr_i = '0; bus.we_i = 1'b0; bus.rready_i = 1'b1;
    #7;
    chk("init_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("init_rdata", 64'(bus.rdata_o), 64'h0);
    chk("init_err", 64'(bus.err_o), 64'h0);
    chk("init_rom_req", 64'(bus.rom_req_o), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive(1, 64'h800, 0, 1);
    drive(1, 64'h804, 0, 1);
    drive(0, 64'h0, 0, 1);
    drive(1, 64'h800, 0, 1);
    drive(1, 64'h808, 0, 1);
    drive(1, 64'h810, 0, 1);
    drive(0, 64'h0, 0, 1);

    // Backpressure: two grants then stall, then drain
    for (int i = 0; i < 5; i++) drive(1, 64'h818 + 64'(8 * i), 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 64'h0, 0, 1);

    drive(1, 64'h898, 0, 1);
    drive(1, 64'h7F8, 0, 1);
    drive(1, 64'h802, 0, 1);
    drive(1, 64'h800, 1, 1);
    drive(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1);
    drive(0, 64'h0, 0, 1);

    drive(1, 64'h820, 0, 0);
    drive(1, 64'h899, 0, 1);
    drive(1, 64'h82C, 0, 0);
    drive(0, 64'h0, 0, 1);
    drive(0, 64'h0, 0, 0);
    drive(0, 64'h0, 0, 1);
    drive(0, 64'h0, 0, 1);

    drive(1, 64'h808, 0, 0);
    drive(1, 64'h80C, 0, 0);
    drive(0, 64'h0, 0, 0);
    do_reset();
    drive(0, 64'h0, 0, 1);
    drive(0, 64'h0, 0, 1);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: a = BASE + 64'(8 * $urandom_range(0, ROMW - 1)) + 64'(4 * $urandom_range(0, 1));
        6: a = BASE + 64'(8 * ROMW) + 64'(4 * $urandom_range(0, 5));
        7: a = BASE + 64'(4 * $urandom_range(0, 2 * ROMW - 1)) + 64'($urandom_range(1, 3));
        8: a = {$urandom(), $urandom()};
        default: a = 64'hFFFF_FFFF_FFFF_FFF8 - 64'(8 * $urandom_range(0, 3));
      endcase
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 10; i++) drive(0, 64'h0, 0, 1);
    chk("drain_empty", 64'(q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
